// File: rtl/eab_agu.sv
// rtl/eab_agu.sv - pipelined effective-address generator with burst output
// Adds PC/Ra base to a sign-extended IR offset, then streams burst_len+1 strided addresses.
module eab_agu #(
    parameter int WIDTH  = 16,
    parameter int IR_W   = 11,
    parameter int BL_W   = 3,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IR_W-1:0]  IR,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] PC,
    input  logic             selEAB1,
    input  logic [1:0]       selEAB2,
    input  logic [BL_W-1:0]  burst_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] addr,
    output logic             addr_last,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [BL_W-1:0]  rem_q, rem_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] base, offset;
    logic             accept, consume;

    // Signed size casts replicate the field's top bit up to WIDTH.
    always_comb begin
        base = selEAB1 ? Ra : PC;
        case (selEAB2)
            2'b00:   offset = '0;
            2'b01:   offset = WIDTH'($signed(IR[5:0]));
            2'b10:   offset = WIDTH'($signed(IR[8:0]));
            default: offset = WIDTH'($signed(IR));
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (consume && last_q && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A request can be taken while the final beat drains, so bursts chain without a gap.
    always_comb begin
        out_valid = (state_q == BURST);
        in_ready  = !out_valid | (out_ready & last_q);
        busy      = out_valid | (rem_q != '0);
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        last_d = last_q;
        if (accept) begin
            addr_d = base + offset;
            rem_d  = burst_len;
            last_d = (burst_len == '0);
        end else if (consume && !last_q) begin
            addr_d = addr_q + STEP;
            rem_d  = rem_q - BL_W'(1);
            last_d = (rem_q == BL_W'(1));
        end else if (consume) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            last_q <= last_d;
        end
    end

    assign addr      = addr_q;
    assign addr_last = last_q;

endmodule

// File: tb/tb_eab_agu.sv
// tb/tb_eab_agu.sv - scoreboard bench for eab_agu: directed cases plus randomized bursts
module tb_eab_agu;

    localparam int WIDTH  = 16;
    localparam int IR_W   = 11;
    localparam int BL_W   = 3;
    localparam int STRIDE = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IR_W-1:0]  IR = '0;
    logic [WIDTH-1:0] Ra = '0;
    logic [WIDTH-1:0] PC = '0;
    logic             selEAB1 = 1'b0;
    logic [1:0]       selEAB2 = 2'b00;
    logic [BL_W-1:0]  burst_len = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] addr;
    logic             addr_last;
    logic             busy;

    eab_agu #(.WIDTH(WIDTH), .IR_W(IR_W), .BL_W(BL_W), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .IR(IR), .Ra(Ra), .PC(PC), .selEAB1(selEAB1), .selEAB2(selEAB2),
        .burst_len(burst_len), .out_valid(out_valid), .out_ready(out_ready),
        .addr(addr), .addr_last(addr_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned a;
        bit          last;
    } beat_t;

    beat_t sbq[$];
    int    total = 0;
    int    bad = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the main sequence
    bit    mon_en = 1'b0;
    bit    acc_with_valid;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sext(input int unsigned v, input int n);
        int r;
        r = int'(v % (1 << n));
        if (r >= (1 << (n - 1))) r -= (1 << n);
        return r;
    endfunction

    // Reference: expected address list from the request fields, plain integer arithmetic.
    task automatic push_model();
        int base, off;
        base = selEAB1 ? int'(Ra) : int'(PC);
        case (selEAB2)
            2'b00:   off = 0;
            2'b01:   off = sext(IR, 6);
            2'b10:   off = sext(IR, 9);
            default: off = sext(IR, IR_W);
        endcase
        for (int i = 0; i <= int'(burst_len); i++) begin
            beat_t b;
            b.a    = int'(unsigned'(base + off + i * STRIDE)) & 32'hFFFF;
            b.last = (i == int'(burst_len));
            sbq.push_back(b);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit s1, input logic [1:0] s2, input int ir, input int ra,
                        input int pc, input int bl);
        bit done;
        done = 1'b0;
        IR = IR_W'(ir); Ra = WIDTH'(ra); PC = WIDTH'(pc);
        selEAB1 = s1; selEAB2 = s2; burst_len = BL_W'(bl);
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            #7;
            if (in_ready) begin
                acc_with_valid = out_valid;
                push_model();
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", out_valid, sbq.size() != 0);
            chk("busy", busy, sbq.size() != 0);
            if (out_valid && out_ready && sbq.size() != 0) begin
                beat_t e;
                e = sbq.pop_front();
                chk("addr", addr, e.a);
                chk("addr_last", addr_last, e.last);
            end
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_addr_last", addr_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        send(1'b0, 2'b10, 'h03F, 'h0000, 'h000F, 0);              // 0x004E single beat
        drain(20);
        send(1'b1, 2'b10, 'h03F, 'h0008, 'h00FF, 3);              // 0x47..0x4A
        drain(20);
        send(1'b0, 2'b11, 'b11000000001, 'h0000, 'h000F, 0);      // 0xFE10
        send(1'b1, 2'b00, 'h7FF, 'h0008, 'h1234, 0);              // 0x0008
        drain(20);
        send(1'b0, 2'b00, 'h000, 'h0000, 'hFFFF, 2);              // wraps through 0
        drain(20);
        send(1'b0, 2'b01, 'h020, 'h0000, 'h0010, 1);              // off6 negative
        drain(20);

        // Backpressure on beat 2, then chained request on the last beat.
        rdy_mode = 2;
        out_ready = 1'b1;
        send(1'b1, 2'b10, 'h03F, 'h0008, 'h00FF, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_addr", addr, 'h0049);
            chk("hold_last", addr_last, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("last_beat_addr", addr, 'h004A);
        send(1'b0, 2'b01, 'h001, 'h0000, 'h0100, 1);
        chk("accept_on_last_beat", acc_with_valid, 1);
        drain(20);

        // Reset during the first beat of a 4-beat burst.
        send(1'b0, 2'b00, 'h000, 'h0000, 'h0200, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        sbq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postrst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rdy_mode = 0;

        rdy_mode = 1;
        for (int n = 0; n < 150; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom),
                 int'($urandom), int'($urandom), int'($urandom_range(0, 7)));
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        drain(100);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
